// File: rtl/udma_ctrl_dp_in_rx.sv
// uDMA data-plane RX engine: peripheral beats in, lane-aligned L2 writes out.
// Registered write buffer between the RX handshake and the L2 request port.
module udma_ctrl_dp_in_rx #(
  parameter int ADDR_W     = 19,
  parameter int SIZE_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_continuous,
  input  logic [ADDR_W-1:0] cfg_startaddr,
  input  logic [SIZE_W-1:0] cfg_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_datasize,
  output logic              l2_req,
  input  logic              l2_gnt,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [31:0]       l2_wdata,
  output logic [3:0]        l2_be,
  output logic              busy,
  output logic [SIZE_W-1:0] bytes_left,
  output logic              eot,
  output logic              err_misalign
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, STOP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] start_q;
  logic [SIZE_W-1:0] size_q;
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;

  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [31:0]       f_data [FIFO_DEPTH];
  logic [3:0]        f_be   [FIFO_DEPTH];

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        stop_hit;
  logic        misalign;
  logic [2:0]  nb;
  logic [2:0]  take;
  logic [1:0]  lane;
  logic [7:0]  mask;
  logic [7:0]  be_w;
  logic [31:0] wdata;
  logic [PW-1:0] rd_idx;

  assign rd_idx     = rd_ptr[PW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign stop_hit = cfg_stop && (state != IDLE);
  assign in_ready = (state == RUN) && !fifo_full;
  assign push     = in_valid && in_ready && !cfg_stop;
  assign l2_req   = !fifo_empty;
  assign pop      = l2_req && l2_gnt;
  assign busy     = (state != IDLE);

  assign l2_addr  = fifo_empty ? '0 : f_addr[rd_idx];
  assign l2_wdata = fifo_empty ? '0 : f_data[rd_idx];
  assign l2_be    = fifo_empty ? '0 : f_be[rd_idx];

  always_comb begin
    nb = 3'd4;
    unique case (1'b1)
      (in_datasize == 2'd0): nb = 3'd1;
      (in_datasize == 2'd1): nb = 3'd2;
      default:               nb = 3'd4;
    endcase
    take = nb;
    if ({{(SIZE_W-3){1'b0}}, nb} > bytes_left)
      take = bytes_left[2:0];
    lane     = addr_q[1:0];
    wdata    = in_data << {lane, 3'b000};
    mask     = (8'd1 << take) - 8'd1;
    be_w     = mask << lane;
    misalign = ((in_datasize == 2'd1) && lane[0]) ||
               (in_datasize[1] && (lane != 2'd0));
  end

  // buffer storage carries no reset; outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_ptr[PW-1:0]] <= {addr_q[ADDR_W-1:2], 2'b00};
      f_data[wr_ptr[PW-1:0]] <= wdata;
      f_be[wr_ptr[PW-1:0]]   <= be_w[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      start_q      <= '0;
      size_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bytes_left   <= '0;
      eot          <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      eot <= 1'b0;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // on abort keep only the head, which is already being requested
      if (stop_hit) begin
        if (!fifo_empty)
          wr_ptr <= rd_ptr + 1'b1;
      end else if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (stop_hit) begin
        state      <= STOP;
        bytes_left <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_start && !cfg_stop) begin
              err_misalign <= 1'b0;
              if (cfg_size != '0) begin
                addr_q     <= cfg_startaddr;
                start_q    <= cfg_startaddr;
                size_q     <= cfg_size;
                bytes_left <= cfg_size;
                state      <= RUN;
              end else begin
                eot <= 1'b1;
              end
            end
          end
          RUN: begin
            if (push) begin
              addr_q     <= addr_q + ADDR_W'(take);
              bytes_left <= bytes_left - SIZE_W'(take);
              if (misalign)
                err_misalign <= 1'b1;
              if (bytes_left == SIZE_W'(take))
                state <= DRAIN;
            end
          end
          DRAIN: begin
            if (fifo_empty) begin
              eot <= 1'b1;
              if (cfg_continuous) begin
                addr_q     <= start_q;
                bytes_left <= size_q;
                state      <= RUN;
              end else begin
                state <= IDLE;
              end
            end
          end
          STOP: begin
            if (fifo_empty)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_ctrl_dp_in_rx.sv
// Directed + randomized bench for udma_ctrl_dp_in_rx.
// Expected L2 writes come from a byte-level transfer model.
module tb_udma_ctrl_dp_in_rx;

  logic        clk;
  logic        reset_n;
  logic        cfg_start;
  logic        cfg_stop;
  logic        cfg_continuous;
  logic [18:0] cfg_startaddr;
  logic [15:0] cfg_size;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_datasize;
  logic        l2_req;
  logic        l2_gnt;
  logic [18:0] l2_addr;
  logic [31:0] l2_wdata;
  logic [3:0]  l2_be;
  logic        busy;
  logic [15:0] bytes_left;
  logic        eot;
  logic        err_misalign;

  udma_ctrl_dp_in_rx dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_start(cfg_start),
    .cfg_stop(cfg_stop),
    .cfg_continuous(cfg_continuous),
    .cfg_startaddr(cfg_startaddr),
    .cfg_size(cfg_size),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_datasize(in_datasize),
    .l2_req(l2_req),
    .l2_gnt(l2_gnt),
    .l2_addr(l2_addr),
    .l2_wdata(l2_wdata),
    .l2_be(l2_be),
    .busy(busy),
    .bytes_left(bytes_left),
    .eot(eot),
    .err_misalign(err_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int eot_cnt = 0;
  bit rnd_gnt = 0;

  int m_addr;
  int m_left;
  bit m_mis;
  logic [31:0] ea[$];
  logic [31:0] ed[$];
  logic [3:0]  eb[$];
  logic [31:0] oa[$];
  logic [31:0] od[$];
  logic [3:0]  ob[$];

  always @(posedge clk) begin
    if (reset_n && l2_req && l2_gnt) begin
      oa.push_back(32'(l2_addr));
      od.push_back(l2_wdata);
      ob.push_back(l2_be);
    end
    if (reset_n && eot)
      eot_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_gnt)
      l2_gnt = 1'($urandom_range(0, 1));
  endtask

  task automatic model_beat(input logic [31:0] d, input int ds);
    int nb;
    int take;
    int lane;
    longint w;
    nb = (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
    take = (nb < m_left) ? nb : m_left;
    lane = m_addr % 4;
    w = longint'(d) * longint'(256 ** lane);
    ed.push_back(w[31:0]);
    eb.push_back(4'((((2 ** take) - 1) * (2 ** lane)) % 16));
    ea.push_back(32'(m_addr - lane));
    if ((nb == 2 && lane % 2 == 1) || (nb == 4 && lane != 0))
      m_mis = 1;
    m_addr = (m_addr + take) % (2 ** 19);
    m_left = m_left - take;
  endtask

  task automatic start_xfer(input int a, input int s);
    cfg_startaddr = 19'(a);
    cfg_size = 16'(s);
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    m_addr = a;
    m_left = s;
    m_mis = 0;
  endtask

  task automatic try_beat(input logic [31:0] d, input int ds,
                          input int bound, output bit ok);
    in_data = d;
    in_datasize = 2'(ds);
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < bound && !in_ready; k++)
      cyc();
    if (in_ready) begin
      cyc();
      ok = 1;
      model_beat(d, ds);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input int ds);
    bit ok;
    try_beat(d, ds, 50, ok);
    chk("beat_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_eot(input string tag);
    for (int k = 0; k < 300 && eot_cnt == 0; k++)
      cyc();
    repeat (3) cyc();
    chk(tag, 64'(eot_cnt), 64'd1);
    eot_cnt = 0;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, 64'(oa.size()), 64'(ea.size()));
    n = (oa.size() < ea.size()) ? oa.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 64'(oa[i]), 64'(ea[i]));
      chk({tag, "_data"}, 64'(od[i]), 64'(ed[i]));
      chk({tag, "_be"}, 64'(ob[i]), 64'(eb[i]));
    end
    oa.delete(); od.delete(); ob.delete();
    ea.delete(); ed.delete(); eb.delete();
  endtask

  initial begin
    bit ok;
    int acc;
    int a;
    int s;
    reset_n = 1'b0;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    cfg_continuous = 1'b0;
    cfg_startaddr = '0;
    cfg_size = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_datasize = '0;
    l2_gnt = 1'b1;
    repeat (3) cyc();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_l2_req", 64'(l2_req), 64'd0);
    chk("rst_l2_addr", 64'(l2_addr), 64'd0);
    chk("rst_l2_wdata", 64'(l2_wdata), 64'd0);
    chk("rst_l2_be", 64'(l2_be), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bytes_left", 64'(bytes_left), 64'd0);
    chk("rst_eot", 64'(eot), 64'd0);
    chk("rst_err", 64'(err_misalign), 64'd0);
    reset_n = 1'b1;
    cyc();
    eot_cnt = 0;

    // two aligned words
    start_xfer(32'h100, 8);
    chk("w2_busy", 64'(busy), 64'd1);
    chk("w2_left", 64'(bytes_left), 64'd8);
    send_beat($urandom, 2);
    send_beat($urandom, 2);
    wait_eot("w2_eot");
    chk("w2_idle", 64'(busy), 64'd0);
    compare_writes("w2");

    // byte lanes from an odd address
    start_xfer(32'h201, 3);
    send_beat(32'hAA, 0);
    send_beat(32'hBB, 0);
    send_beat(32'hCC, 0);
    wait_eot("b3_eot");
    chk("b3_err", 64'(err_misalign), 64'd0);
    compare_writes("b3");

    // word beat truncated by remaining size
    start_xfer(32'h40, 3);
    send_beat(32'h11223344, 2);
    chk("tr_left", 64'(bytes_left), 64'd0);
    chk("tr_ready", 64'(in_ready), 64'd0);
    wait_eot("tr_eot");
    chk("tr_err", 64'(err_misalign), 64'd0);
    compare_writes("tr");

    // misaligned half sets sticky error, next start clears it
    start_xfer(32'h101, 2);
    send_beat($urandom, 1);
    wait_eot("ma_eot");
    chk("ma_err", 64'(err_misalign), 64'(m_mis));
    compare_writes("ma");
    start_xfer(32'h104, 4);
    chk("ma_clr", 64'(err_misalign), 64'd0);
    send_beat($urandom, 2);
    wait_eot("ma2_eot");
    compare_writes("ma2");

    // zero-length transfer
    start_xfer(32'h10, 0);
    chk("z_eot", 64'(eot), 64'd1);
    chk("z_busy", 64'(busy), 64'd0);
    cyc();
    cyc();
    chk("z_cnt", 64'(eot_cnt), 64'd1);
    eot_cnt = 0;

    // buffer full with grant held low, then abort
    l2_gnt = 1'b0;
    start_xfer(32'h300, 20);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      try_beat($urandom, 2, 6, ok);
      acc += int'(ok);
    end
    chk("full_acc", 64'(acc), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_req", 64'(l2_req), 64'd1);
    chk("full_addr", 64'(l2_addr), 64'h300);
    repeat (3) cyc();
    chk("full_hold", 64'(l2_addr), 64'h300);
    repeat (3) begin
      void'(ea.pop_back());
      void'(ed.pop_back());
      void'(eb.pop_back());
    end
    cfg_stop = 1'b1;
    cyc();
    cfg_stop = 1'b0;
    chk("stop_busy", 64'(busy), 64'd1);
    chk("stop_left", 64'(bytes_left), 64'd0);
    chk("stop_req", 64'(l2_req), 64'd1);
    cyc();
    chk("stop_addr", 64'(l2_addr), 64'h300);
    l2_gnt = 1'b1;
    cyc();
    repeat (3) cyc();
    chk("stop_idle", 64'(busy), 64'd0);
    chk("stop_req0", 64'(l2_req), 64'd0);
    chk("stop_noeot", 64'(eot_cnt), 64'd0);
    compare_writes("stop");

    // continuous reload
    cfg_continuous = 1'b1;
    start_xfer(32'h500, 4);
    send_beat($urandom, 2);
    wait_eot("ct_eot1");
    chk("ct_busy", 64'(busy), 64'd1);
    chk("ct_left", 64'(bytes_left), 64'd4);
    m_addr = 32'h500;
    m_left = 4;
    send_beat($urandom, 2);
    wait_eot("ct_eot2");
    cfg_continuous = 1'b0;
    compare_writes("ct");
    cfg_stop = 1'b1;
    cyc();
    cfg_stop = 1'b0;
    repeat (2) cyc();
    chk("ct_stop", 64'(busy), 64'd0);

    // randomized transfers with random grant, one crossing the top
    rnd_gnt = 1;
    for (int t = 0; t < 5; t++) begin
      a = (t == 0) ? 32'h7FFFE : int'($urandom_range(0, 32'h7FFFF));
      s = int'($urandom_range(1, 12));
      start_xfer(a, s);
      while (m_left > 0)
        send_beat($urandom, int'($urandom_range(0, 3)));
      wait_eot("rnd_eot");
      chk("rnd_err", 64'(err_misalign), 64'(m_mis));
      compare_writes("rnd");
    end
    rnd_gnt = 0;
    l2_gnt = 1'b1;
    cyc();

    // reset in the middle of a transfer
    start_xfer(32'h600, 8);
    send_beat(32'h5A, 0);
    cyc();
    compare_writes("pre_rst");
    in_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mr_ready", 64'(in_ready), 64'd0);
    chk("mr_req", 64'(l2_req), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_left", 64'(bytes_left), 64'd0);
    chk("mr_addr", 64'(l2_addr), 64'd0);
    chk("mr_be", 64'(l2_be), 64'd0);
    in_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    repeat (4) cyc();
    chk("mr_noeot", 64'(eot_cnt), 64'd0);
    chk("mr_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
